flash_sample_reader: RTL

Producer side of the sample-word handshake: fetches 32-bit sample words from the flash controller over an Avalon-MM pipelined read port and presents each to the audio output stage with a level `finish` flag. Advances the word address forward or backward only when the audio stage releases `hold`, wrapping at the ends of the sample region. It sits between the flash controller and the 22 kHz audio output FSM.

---
 rtl/flash_audio_pkg.sv | 22 ++
 rtl/flash_addr_step.sv | 32 +++
 rtl/flash_sample_reader.sv | 100 ++++++++++
 3 files changed

// File: rtl/flash_audio_pkg.sv
`default_nettype none
// ============================================================================
// Module   : flash_audio_pkg
// Brief    : Shared state encodings and region defaults for the flash audio
//            sample path (reader and audio output FSM).
// Revision : 1.0 - initial release
// ============================================================================
package flash_audio_pkg;

    localparam int                    c_addr_w   = 23;
    localparam logic [c_addr_w-1:0]   c_max_addr = 23'h7FFFF;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_REQ       = 3'd1,
        ST_WAIT_DATA = 3'd2,
        ST_DONE      = 3'd3,
        ST_ADVANCE   = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/flash_addr_step.sv
`default_nettype none
// ============================================================================
// Module   : flash_addr_step
// Brief    : Combinational next word address with direction, restart and
//            wrap at both ends of the sample region.
// Revision : 1.0 - initial release
// ============================================================================
module flash_addr_step
    import flash_audio_pkg::*;
#(
    parameter int                ADDR_W   = c_addr_w,
    parameter logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(c_max_addr)
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              direction,
    input  logic              restart,
    output logic [ADDR_W-1:0] next_addr
);

    always_comb begin
        next_addr = addr;
        if (restart) begin
            next_addr = direction ? MAX_ADDR : '0;
        end else if (!direction) begin
            next_addr = (addr == MAX_ADDR) ? '0 : addr + ADDR_W'(1);
        end else begin
            next_addr = (addr == '0) ? MAX_ADDR : addr - ADDR_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/flash_sample_reader.sv
`default_nettype none
// ============================================================================
// Module   : flash_sample_reader
// Brief    : Fetches 32-bit sample words over an Avalon-MM pipelined read
//            port and hands each to the audio stage with a level finish flag.
// Revision : 1.0 - initial release
// ============================================================================
module flash_sample_reader
    import flash_audio_pkg::*;
#(
    parameter int                ADDR_W   = c_addr_w,
    parameter logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(c_max_addr)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              direction,
    input  logic              restart,
    input  logic              hold,
    output logic              flash_mem_read,
    input  logic              flash_mem_waitrequest,
    output logic [ADDR_W-1:0] flash_mem_address,
    output logic [3:0]        flash_mem_byteenable,
    input  logic [31:0]       flash_mem_readdata,
    input  logic              flash_mem_readdatavalid,
    output logic [31:0]       audio_data,
    output logic              finish
);

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic              r_restart_pend;
    logic [ADDR_W-1:0] w_next_addr;

    assign flash_mem_byteenable = 4'hF;
    assign flash_mem_address    = r_addr;

    flash_addr_step #(
        .ADDR_W   (ADDR_W),
        .MAX_ADDR (MAX_ADDR)
    ) u_addr_step (
        .addr      (r_addr),
        .direction (direction),
        .restart   (r_restart_pend),
        .next_addr (w_next_addr)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_addr         <= '0;
            r_restart_pend <= 1'b0;
            flash_mem_read <= 1'b0;
            audio_data     <= 32'h0;
            finish         <= 1'b0;
        end else begin
            if (restart) begin
                r_restart_pend <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    flash_mem_read <= 1'b1;
                    r_state        <= ST_REQ;
                end
                ST_REQ: begin
                    if (!flash_mem_waitrequest) begin
                        flash_mem_read <= 1'b0;
                        r_state        <= ST_WAIT_DATA;
                    end
                end
                ST_WAIT_DATA: begin
                    if (flash_mem_readdatavalid) begin
                        audio_data <= flash_mem_readdata;
                        finish     <= 1'b1;
                        r_state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!hold) begin
                        finish  <= 1'b0;
                        r_state <= ST_ADVANCE;
                    end
                end
                ST_ADVANCE: begin
                    r_addr         <= w_next_addr;
                    // A pulse arriving in this very cycle is kept for the next word.
                    r_restart_pend <= restart;
                    flash_mem_read <= 1'b1;
                    r_state        <= ST_REQ;
                end
                default: begin
                    flash_mem_read <= 1'b0;
                    finish         <= 1'b0;
                    r_state        <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
